gemm_result_drain: RTL and testbench

//  Readback engine for the output-stationary GeMM accelerator's C SRAM. After a GeMM run completes, it

---
 rtl/gemm_result_drain.sv | 115 +++++++++++
 tb/tb_gemm_result_drain.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/gemm_result_drain.sv
// gemm_result_drain: reads every result tile from C SRAM and streams its elements with row/col tags
//  clk_i, rst_i                  clock, synchronous active-high reset
//  start_i, M_size_i, N_size_i   drain request and matrix size (sampled in IDLE)
//  sram_c_addr_o/re_o/rdata_i    C SRAM read port, one-cycle read latency
//  data_o, row_o, col_o          current element and its matrix coordinates
//  valid_o, ready_i, last_o      element stream handshake, final-element marker
//  busy_o, done_o                drain in progress, one-cycle completion pulse
module gemm_result_drain #(
    parameter int OutDataWidth  = 32,
    parameter int OutMemWidth   = 512,
    parameter int AddrWidth     = 16,
    parameter int SizeAddrWidth = 8,
    parameter int NumPE_M       = 4,
    parameter int NumPE_N       = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic [SizeAddrWidth-1:0] M_size_i,
    input  logic [SizeAddrWidth-1:0] N_size_i,
    output logic [AddrWidth-1:0]     sram_c_addr_o,
    output logic                     sram_c_re_o,
    input  logic [OutMemWidth-1:0]   sram_c_rdata_i,
    output logic [OutDataWidth-1:0]  data_o,
    output logic [SizeAddrWidth-1:0] row_o,
    output logic [SizeAddrWidth-1:0] col_o,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic                     last_o,
    output logic                     busy_o,
    output logic                     done_o
);
    localparam int Lanes = NumPE_M * NumPE_N;
    localparam int LaneW = $clog2(Lanes);
    localparam int MSh   = $clog2(NumPE_M);
    localparam int NSh   = $clog2(NumPE_N);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, STREAM, DONE} state_e;

    state_e                   state_q, state_d;
    logic [SizeAddrWidth-1:0] mt_q, nt_q, m_tiles_q, n_tiles_q, n_size_q;
    logic [LaneW-1:0]         lane_q;
    logic [OutMemWidth-1:0]   hold_q;
    logic [AddrWidth-1:0]     addr_q, tile_addr;
    logic                     hs, last_lane, last_tile, no_tiles, nt_wrap;

    assign tile_addr = AddrWidth'(int'(mt_q) * int'(n_size_q) + int'(nt_q));
    assign no_tiles  = ((M_size_i >> MSh) == '0) || ((N_size_i >> NSh) == '0);
    assign hs        = (state_q == STREAM) && ready_i;
    assign last_lane = lane_q == LaneW'(Lanes - 1);
    assign nt_wrap   = (nt_q + 1'b1) == n_tiles_q;
    assign last_tile = ((mt_q + 1'b1) == m_tiles_q) && nt_wrap;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start_i ? (no_tiles ? DONE : REQ) : IDLE;
            REQ:     state_d = WAIT;
            WAIT:    state_d = STREAM;
            STREAM:  state_d = (hs && last_lane) ? (last_tile ? DONE : REQ) : STREAM;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mt_q      <= '0;
            nt_q      <= '0;
            m_tiles_q <= '0;
            n_tiles_q <= '0;
            n_size_q  <= '0;
            lane_q    <= '0;
            hold_q    <= '0;
            addr_q    <= '0;
        end else begin
            if (state_q == IDLE && start_i) begin
                m_tiles_q <= M_size_i >> MSh;
                n_tiles_q <= N_size_i >> NSh;
                n_size_q  <= N_size_i;
                mt_q      <= '0;
                nt_q      <= '0;
                lane_q    <= '0;
            end
            if (state_q == REQ) addr_q <= tile_addr;
            if (state_q == WAIT) begin
                hold_q <= sram_c_rdata_i;
                lane_q <= '0;
            end
            if (hs) begin
                lane_q <= lane_q + 1'b1;
                if (last_lane) begin
                    nt_q <= nt_wrap ? '0 : nt_q + 1'b1;
                    mt_q <= nt_wrap ? mt_q + 1'b1 : mt_q;
                end
            end
        end
    end

    // The address register only tracks issued reads, so the port holds its value between reads.
    assign sram_c_re_o   = state_q == REQ;
    assign sram_c_addr_o = sram_c_re_o ? tile_addr : addr_q;
    assign data_o        = hold_q[int'(lane_q) * OutDataWidth +: OutDataWidth];
    assign row_o         = SizeAddrWidth'(int'(mt_q) * NumPE_M + int'(lane_q) / NumPE_N);
    assign col_o         = SizeAddrWidth'(int'(nt_q) * NumPE_N + int'(lane_q) % NumPE_N);
    assign valid_o       = state_q == STREAM;
    assign last_o        = valid_o && last_lane && last_tile;
    assign busy_o        = (state_q == REQ) || (state_q == WAIT) || (state_q == STREAM);
    assign done_o        = state_q == DONE;
endmodule

// File: tb/tb_gemm_result_drain.sv
// tb_gemm_result_drain: directed table and corner-case sequences for gemm_result_drain
module tb_gemm_result_drain;
    localparam int DW = 32, MW = 512, AW = 16, SW = 8;

    logic          clk_i = 1'b0, rst_i = 1'b1, start_i = 1'b0, ready_i = 1'b1;
    logic [SW-1:0] m_size = '0, n_size = '0;
    logic [MW-1:0] rdata = '0;
    logic [AW-1:0] sram_c_addr_o;
    logic          sram_c_re_o, valid_o, last_o, busy_o, done_o;
    logic [DW-1:0] data_o;
    logic [SW-1:0] row_o, col_o;

    gemm_result_drain dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .M_size_i(m_size), .N_size_i(n_size),
        .sram_c_addr_o(sram_c_addr_o), .sram_c_re_o(sram_c_re_o), .sram_c_rdata_i(rdata),
        .data_o(data_o), .row_o(row_o), .col_o(col_o), .valid_o(valid_o), .ready_i(ready_i),
        .last_o(last_o), .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0, errors = 0;
    int cyc = 0, t0 = 0;
    int cur_m = 0, cur_n = 0;
    int reads, beats, dones, valids, re_lat, val_lat, last_lat, done_lat;
    logic          sp_en = 1'b0;
    logic [DW-1:0] sp_val = 32'h8000_0000;

    typedef struct {
        int m, n, reads, beats, re_lat, val_lat, last_lat, done_lat;
    } vec_t;
    vec_t tbl[6];

    function automatic logic [DW-1:0] elem(int addr, int l);
        if (sp_en && addr == 0 && l == 5) return sp_val;
        return DW'(addr * 16 + l - 8);
    endfunction

    function automatic logic [MW-1:0] mk_word(int addr);
        logic [MW-1:0] w;
        for (int l = 0; l < 16; l++) w[l*DW +: DW] = elem(addr, l);
        return w;
    endfunction

    always @(posedge clk_i) if (sram_c_re_o) rdata <= mk_word(int'(sram_c_addr_o));

    function automatic int ntc();
        return (cur_n / 4 == 0) ? 1 : cur_n / 4;
    endfunction

    function automatic logic [AW-1:0] exp_addr(int j);
        return AW'((j / ntc()) * cur_n + j % ntc());
    endfunction

    function automatic logic [48:0] exp_beat(int k);
        int tile, l, mt, nt, total;
        tile  = k / 16;
        l     = k % 16;
        mt    = tile / ntc();
        nt    = tile % ntc();
        total = (cur_m / 4) * (cur_n / 4) * 16;
        return {elem(mt * cur_n + nt, l), SW'(mt * 4 + l / 4), SW'(nt * 4 + l % 4), k == total - 1};
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic sample();
        if (sram_c_re_o) begin
            chk("rd_addr", 64'(sram_c_addr_o), 64'(exp_addr(reads)));
            if (reads == 0) re_lat = cyc - t0;
            reads++;
        end
        if (valid_o) valids++;
        if (valid_o && ready_i) begin
            chk("beat", 64'({data_o, row_o, col_o, last_o}), 64'(exp_beat(beats)));
            if (beats == 0) val_lat = cyc - t0;
            if (last_o) last_lat = cyc - t0;
            beats++;
        end
        if (done_o) begin
            dones++;
            done_lat = cyc - t0;
        end
    endtask

    task automatic tick();
        @(negedge clk_i);
        sample();
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    task automatic start_drain(int m, int n);
        cur_m = m; cur_n = n;
        reads = 0; beats = 0; dones = 0; valids = 0;
        re_lat = -1; val_lat = -1; last_lat = -1; done_lat = -1;
        m_size = SW'(m); n_size = SW'(n);
        start_i = 1'b1;
        t0 = cyc;
        tick();
        start_i = 1'b0;
    endtask

    task automatic wait_done(int budget);
        int b = budget;
        while (dones == 0 && b > 0) begin
            tick();
            b--;
        end
        chk("done_seen", 64'(dones > 0), 64'd1);
        repeat (3) tick();
    endtask

    task automatic run_vec(vec_t v);
        start_drain(v.m, v.n);
        wait_done(300);
        chk("reads", 64'(reads), 64'(v.reads));
        chk("beats", 64'(beats), 64'(v.beats));
        chk("done_pulses", 64'(dones), 64'd1);
        chk("done_lat", 64'(done_lat), 64'(v.done_lat));
        chk("re_lat", 64'(re_lat), 64'(v.re_lat));
        chk("valid_lat", 64'(val_lat), 64'(v.val_lat));
        chk("last_lat", 64'(last_lat), 64'(v.last_lat));
        if (v.beats == 0) chk("valid_never", 64'(valids), 64'd0);
    endtask

    task automatic chk_zero(string name);
        chk(name, 64'({sram_c_addr_o, sram_c_re_o, valid_o, last_o, busy_o, done_o}), 64'd0);
        chk({name, "_data"}, 64'({data_o, row_o, col_o}), 64'd0);
    endtask

    initial begin
        tbl[0] = '{4, 4, 1, 16, 1, 3, 18, 19};
        tbl[1] = '{8, 8, 4, 64, 1, 3, 72, 73};
        tbl[2] = '{0, 8, 0, 0, -1, -1, -1, 1};
        tbl[3] = '{4, 3, 0, 0, -1, -1, -1, 1};
        tbl[4] = '{8, 4, 2, 32, 1, 3, 36, 37};
        tbl[5] = '{9, 6, 2, 32, 1, 3, 36, 37};

        repeat (3) tick();
        chk_zero("reset");
        rst_i = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) run_vec(tbl[i]);

        // backpressure: lane 3 is presented in cycle t+6, stall it for 5 cycles
        start_drain(4, 4);
        repeat (5) tick();
        ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("stall_hold", 64'({data_o, row_o, col_o, last_o, valid_o}),
                64'({elem(0, 3), 8'd0, 8'd3, 1'b0, 1'b1}));
            chk("stall_no_re", 64'(sram_c_re_o), 64'd0);
            tick();
        end
        ready_i = 1'b1;
        wait_done(300);
        chk("stall_beats", 64'(beats), 64'd16);
        chk("stall_reads", 64'(reads), 64'd1);
        chk("stall_done_lat", 64'(done_lat), 64'd24);

        // reset at lane 7 of tile 1 (cycle t+28), then a clean restart
        start_drain(8, 8);
        repeat (27) tick();
        chk("pre_reset_pos", 64'({row_o, col_o, sram_c_addr_o}), 64'({8'd1, 8'd7, 16'd1}));
        rst_i = 1'b1;
        tick();
        chk_zero("mid_reset");
        rst_i = 1'b0;
        tick();
        chk("post_reset_idle", 64'({busy_o, valid_o, sram_c_re_o}), 64'd0);
        run_vec(tbl[1]);

        // stray starts mid-drain and during done, plus a min-negative element
        sp_en = 1'b1;
        start_drain(4, 4);
        repeat (7) tick();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (10) tick();
        chk("done_at_t19", 64'(done_o), 64'd1);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (30) tick();
        chk("stray_reads", 64'(reads), 64'd1);
        chk("stray_beats", 64'(beats), 64'd16);
        chk("stray_dones", 64'(dones), 64'd1);
        chk("stray_idle", 64'({busy_o, valid_o}), 64'd0);
        sp_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
